// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU arbiter: op encoding, FSM states,
// and the default watchdog / ALU reset lengths.
package alu_pkg;

    typedef enum logic [2:0] {
        NO_OP  = 3'b000,
        ADD    = 3'b001,
        AND    = 3'b010,
        XOR    = 3'b011,
        MUL    = 3'b100,
        RST_OP = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        ALU_RST = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    localparam int DEF_TIMEOUT    = 16;
    localparam int DEF_RST_CYCLES = 2;

    // Codes 101 and 110 have no ALU meaning; they run as NO_OP and flag an error.
    function automatic logic op_illegal(logic [2:0] op);
        return (op == 3'b101) || (op == 3'b110);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// ALU-side bus: start/done handshake, operands, result and ALU reset.
// master = arbiter, slave = ALU.
interface alu_arbiter_if;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        reset_n;
    logic        done;
    logic [15:0] result;

    modport master (output start, op, a, b, reset_n, input done, result);
    modport slave  (input start, op, a, b, reset_n, output done, result);
endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit starting at ptr+1,
// wrapping modulo NUM_REQ. ptr itself is searched last.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         sel,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       vld
);
    localparam int IDW = $clog2(NUM_REQ);

    // Scan from ptr+1 upward; the first hit wins.
    always_comb begin
        int cand;
        cand = 0;
        sel  = '0;
        idx  = '0;
        vld  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!vld && ((req >> cand) & NUM_REQ'(1)) != '0) begin
                vld = 1'b1;
                idx = IDW'(cand);
                sel = NUM_REQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters: round-robin grant, one op in
// flight, start/done sequencing, reset-request pulses and a hang watchdog.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0][2:0] req_op,
    input  logic [NUM_REQ-1:0][7:0] req_a,
    input  logic [NUM_REQ-1:0][7:0] req_b,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [15:0]             rsp_result,
    output logic                    rsp_err,
    alu_arbiter_if.master           alu,
    output logic                    busy
);
    localparam int IDW  = $clog2(NUM_REQ);
    localparam int MAXC = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    arb_state_e         state;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     id;
    logic [CW-1:0]      cnt;     // EXEC watchdog, reused as ALU_RST length counter
    logic               nop;     // current op completes without waiting for done
    logic               err;     // illegal op or watchdog abort

    logic [NUM_REQ-1:0] pick_sel;
    logic [IDW-1:0]     pick_idx;
    logic               pick_vld;
    alu_op_e            sel_op;
    logic               sel_ill;
    logic [NUM_REQ-1:0] id_oh;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req (req),
        .ptr (ptr),
        .sel (pick_sel),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    assign sel_op  = alu_op_e'(req_op[pick_idx]);
    assign sel_ill = op_illegal(req_op[pick_idx]);
    assign id_oh   = NUM_REQ'(1) << id;

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            id          <= '0;
            cnt         <= '0;
            nop         <= 1'b0;
            err         <= 1'b0;
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_result  <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            alu.start   <= 1'b0;
            alu.op      <= '0;
            alu.a       <= '0;
            alu.b       <= '0;
            alu.reset_n <= 1'b0;
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    alu.reset_n <= 1'b1;
                    if (pick_vld) begin
                        id   <= pick_idx;
                        ptr  <= pick_idx;
                        gnt  <= pick_sel;
                        busy <= 1'b1;
                        cnt  <= '0;
                        if (sel_op == RST_OP) begin
                            state       <= ALU_RST;
                            alu.reset_n <= 1'b0;
                            err         <= 1'b0;
                        end else begin
                            state     <= EXEC;
                            alu.start <= 1'b1;
                            alu.op    <= sel_ill ? NO_OP : sel_op;
                            alu.a     <= req_a[pick_idx];
                            alu.b     <= req_b[pick_idx];
                            nop       <= sel_ill || (sel_op == NO_OP);
                            err       <= sel_ill;
                        end
                    end
                end
                EXEC: begin
                    if (nop) begin
                        alu.start  <= 1'b0;
                        state      <= RESP;
                        rsp_valid  <= id_oh;
                        rsp_result <= '0;
                        rsp_err    <= err;
                    end else if (alu.done) begin
                        alu.start  <= 1'b0;
                        state      <= RESP;
                        rsp_valid  <= id_oh;
                        rsp_result <= alu.result;
                        rsp_err    <= 1'b0;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        alu.start   <= 1'b0;
                        alu.reset_n <= 1'b0;
                        state       <= ALU_RST;
                        err         <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ALU_RST: begin
                    if (cnt == CW'(RST_CYCLES - 1)) begin
                        alu.reset_n <= 1'b1;
                        state       <= RESP;
                        rsp_valid   <= id_oh;
                        rsp_result  <= '0;
                        rsp_err     <= err;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a behavioural ALU and a
// transaction-level reference (round-robin order, per-op timing/results).
module tb_alu_arbiter;
    localparam int NREQ = 4;
    localparam int TO   = 16;
    localparam int RSTC = 2;

    logic                 clk;
    logic                 reset_n;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0][2:0] req_op;
    logic [NREQ-1:0][7:0] req_a;
    logic [NREQ-1:0][7:0] req_b;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rsp_valid;
    logic [15:0]          rsp_result;
    logic                 rsp_err;
    logic                 busy;

    logic [2:0] op_t [NREQ];
    logic [7:0] a_t  [NREQ];
    logic [7:0] b_t  [NREQ];

    int total = 0;
    int bad   = 0;
    int mptr  = 0;     // model round-robin pointer
    int alu_lat = 2;
    bit alu_hang = 0;

    alu_arbiter_if alu_if_i ();

    alu_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TO), .RST_CYCLES(RSTC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .alu        (alu_if_i),
        .busy       (busy)
    );

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        assign req_op[g] = op_t[g];
        assign req_a[g]  = a_t[g];
        assign req_b[g]  = b_t[g];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] alu_ref(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            3'b001:  return 16'(a) + 16'(b);
            3'b010:  return {8'h00, a & b};
            3'b011:  return {8'h00, a ^ b};
            3'b100:  return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit is_alu_op(logic [2:0] op);
        return op >= 3'b001 && op <= 3'b100;
    endfunction

    function automatic int rr_next(logic [NREQ-1:0] m, int p);
        for (int k = 1; k <= NREQ; k++)
            if (((m >> ((p + k) % NREQ)) & NREQ'(1)) != '0) return (p + k) % NREQ;
        return -1;
    endfunction

    // Cycle (relative to the IDLE sample) at which rsp_valid is seen.
    function automatic int exp_rsp_cyc(logic [2:0] op, int lat, bit hang);
        if (op == 3'b111) return RSTC + 1;
        if (!is_alu_op(op)) return 2;
        return hang ? TO + RSTC + 1 : lat + 1;
    endfunction

    function automatic int exp_start(logic [2:0] op, int lat, bit hang);
        if (op == 3'b111) return 0;
        if (!is_alu_op(op)) return 1;
        return hang ? TO : lat;
    endfunction

    function automatic int exp_rstlow(logic [2:0] op, bit hang);
        if (op == 3'b111) return RSTC;
        return (is_alu_op(op) && hang) ? RSTC : 0;
    endfunction

    function automatic logic exp_err(logic [2:0] op, bit hang);
        if (op == 3'b101 || op == 3'b110) return 1'b1;
        return is_alu_op(op) && hang;
    endfunction

    function automatic logic [15:0] exp_res(logic [2:0] op, logic [7:0] a, logic [7:0] b, bit hang);
        return (is_alu_op(op) && !hang) ? alu_ref(op, a, b) : 16'h0000;
    endfunction

    function automatic int oh_idx(logic [NREQ-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int k = 0; k < NREQ; k++)
            if (((v >> k) & NREQ'(1)) != '0) return k;
        return -1;
    endfunction

    // ---------------- behavioural ALU ----------------
    initial begin
        int cnt;
        cnt = 0;
        alu_if_i.done   = 1'b0;
        alu_if_i.result = 16'h0000;
        forever begin
            @(negedge clk);
            if (alu_if_i.start === 1'b1 && !alu_hang) begin
                cnt++;
                if (cnt == alu_lat) begin
                    alu_if_i.done   = 1'b1;
                    alu_if_i.result = alu_ref(alu_if_i.op, alu_if_i.a, alu_if_i.b);
                end else begin
                    alu_if_i.done = 1'b0;
                end
            end else begin
                cnt = 0;
                alu_if_i.done = 1'b0;
            end
        end
    end

    // Watches one transaction from the cycle after req is set until rsp_valid.
    task automatic observe(input bit drop, output int g_cyc, output int g_idx, output int g_w,
                           output int s_cnt, output int r_cnt, output int p_cyc, output int p_idx,
                           output logic [15:0] p_res, output logic p_err);
        g_cyc = -1; g_idx = -1; g_w = 0; s_cnt = 0; r_cnt = 0;
        p_cyc = -1; p_idx = -1; p_res = 16'hxxxx; p_err = 1'bx;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                g_w++;
                if (g_cyc < 0) begin
                    g_cyc = c;
                    g_idx = oh_idx(gnt);
                    if (drop && g_idx >= 0) req = req & ~(NREQ'(1) << g_idx);
                end
            end
            if (alu_if_i.start === 1'b1) s_cnt++;
            if (alu_if_i.reset_n === 1'b0) r_cnt++;
            if (rsp_valid != '0) begin
                p_cyc = c; p_idx = oh_idx(rsp_valid); p_res = rsp_result; p_err = rsp_err;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({gnt, rsp_valid, rsp_result, rsp_err, busy} !== '0) begin
            bad++; $display("FAIL reset_outs got=%h want=0", {gnt, rsp_valid, rsp_result, rsp_err, busy});
        end
        total++;
        if ({alu_if_i.start, alu_if_i.op, alu_if_i.a, alu_if_i.b, alu_if_i.reset_n} !== '0) begin
            bad++; $display("FAIL reset_alu got=%h want=0",
                {alu_if_i.start, alu_if_i.op, alu_if_i.a, alu_if_i.b, alu_if_i.reset_n});
        end
        reset_n = 1'b1;
        mptr = 0;
        @(negedge clk);
        total++;
        if (alu_if_i.reset_n !== 1'b1) begin
            bad++; $display("FAIL reset_release alu_reset_n got=%b want=1", alu_if_i.reset_n);
        end
    endtask

    task automatic test_single_add();
        int gc, gi, gw, sc, rc, pc, pi; logic [15:0] pr; logic pe;
        alu_hang = 0; alu_lat = 2;
        @(negedge clk);
        op_t[0] = 3'b001; a_t[0] = 8'd3; b_t[0] = 8'd4; req = 4'b0001;
        observe(1, gc, gi, gw, sc, rc, pc, pi, pr, pe);
        mptr = rr_next(4'b0001, mptr);
        total++; if (gc !== 1 || gi !== 0 || gw !== 1) begin
            bad++; $display("FAIL add_gnt got cyc=%0d idx=%0d w=%0d want 1/0/1", gc, gi, gw); end
        total++; if (pc !== 3 || pi !== 0) begin
            bad++; $display("FAIL add_rsp got cyc=%0d idx=%0d want 3/0", pc, pi); end
        total++; if (pr !== 16'd7 || pe !== 1'b0) begin
            bad++; $display("FAIL add_result got res=%0d err=%b want 7/0", pr, pe); end
    endtask

    task automatic test_fairness();
        int gc, gi, gw, sc, rc, pc, pi, ex; logic [15:0] pr; logic pe;
        alu_hang = 0;
        @(negedge clk);
        for (int r = 0; r < NREQ; r++) begin op_t[r] = 3'b100; a_t[r] = 8'd2; b_t[r] = 8'd3; end
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            alu_lat = 1 + int'($urandom_range(2));
            observe(0, gc, gi, gw, sc, rc, pc, pi, pr, pe);
            ex = rr_next(4'b1111, mptr);
            mptr = ex;
            total++; if (gi !== ex || pi !== ex) begin
                bad++; $display("FAIL fair_order n=%0d got gnt=%0d rsp=%0d want %0d", n, gi, pi, ex); end
            total++; if (pr !== 16'd6 || pe !== 1'b0) begin
                bad++; $display("FAIL fair_result n=%0d got res=%0d err=%b want 6/0", n, pr, pe); end
        end
        req = '0;
    endtask

    task automatic test_noop();
        int gc, gi, gw, sc, rc, pc, pi; logic [15:0] pr; logic pe;
        alu_hang = 1;
        @(negedge clk);
        op_t[2] = 3'b000; a_t[2] = 8'h55; b_t[2] = 8'h66; req = 4'b0100;
        observe(1, gc, gi, gw, sc, rc, pc, pi, pr, pe);
        mptr = rr_next(4'b0100, mptr);
        total++; if (sc !== 1 || pc !== 2 || pi !== 2) begin
            bad++; $display("FAIL noop_timing got start=%0d rsp=%0d idx=%0d want 1/2/2", sc, pc, pi); end
        total++; if (pr !== 16'd0 || pe !== 1'b0) begin
            bad++; $display("FAIL noop_result got res=%0d err=%b want 0/0", pr, pe); end
    endtask

    task automatic test_watchdog();
        int gc, gi, gw, sc, rc, pc, pi; logic [15:0] pr; logic pe;
        alu_hang = 1;
        @(negedge clk);
        op_t[3] = 3'b001; a_t[3] = 8'd9; b_t[3] = 8'd9; req = 4'b1000;
        observe(1, gc, gi, gw, sc, rc, pc, pi, pr, pe);
        mptr = rr_next(4'b1000, mptr);
        total++; if (sc !== TO || rc !== RSTC) begin
            bad++; $display("FAIL wdog_timing got start=%0d rstlow=%0d want %0d/%0d", sc, rc, TO, RSTC); end
        total++; if (pc !== TO + RSTC + 1 || pi !== 3) begin
            bad++; $display("FAIL wdog_rsp got cyc=%0d idx=%0d want %0d/3", pc, pi, TO + RSTC + 1); end
        total++; if (pr !== 16'd0 || pe !== 1'b1) begin
            bad++; $display("FAIL wdog_result got res=%0d err=%b want 0/1", pr, pe); end
        alu_hang = 0;
    endtask

    task automatic test_rst_op();
        int gc, gi, gw, sc, rc, pc, pi; logic [15:0] pr; logic pe;
        @(negedge clk);
        op_t[1] = 3'b111; a_t[1] = 8'd1; b_t[1] = 8'd2; req = 4'b0010;
        observe(1, gc, gi, gw, sc, rc, pc, pi, pr, pe);
        mptr = rr_next(4'b0010, mptr);
        total++; if (sc !== 0 || rc !== RSTC || gi !== 1) begin
            bad++; $display("FAIL rstop_timing got start=%0d rstlow=%0d gnt=%0d want 0/%0d/1", sc, rc, gi, RSTC); end
        total++; if (pc !== RSTC + 1 || pi !== 1 || pe !== 1'b0 || pr !== 16'd0) begin
            bad++; $display("FAIL rstop_rsp got cyc=%0d idx=%0d err=%b res=%0d want %0d/1/0/0", pc, pi, pe, pr, RSTC + 1); end
    endtask

    task automatic test_random();
        int gc, gi, gw, sc, rc, pc, pi, ex; logic [15:0] pr; logic pe;
        logic [NREQ-1:0] m;
        logic [2:0] eo;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            m = NREQ'($urandom_range(15, 1));
            for (int r = 0; r < NREQ; r++) begin
                op_t[r] = 3'($urandom_range(7)); a_t[r] = 8'($urandom); b_t[r] = 8'($urandom);
            end
            alu_lat  = 1 + int'($urandom_range(3));
            alu_hang = ($urandom_range(5) == 0);
            req = m;
            observe(1, gc, gi, gw, sc, rc, pc, pi, pr, pe);
            req = '0;
            ex = rr_next(m, mptr);
            mptr = ex;
            eo = op_t[ex];
            total++; if (gi !== ex || pi !== ex || gc !== 1 || gw !== 1) begin
                bad++; $display("FAIL rnd_grant n=%0d m=%b got gnt=%0d rsp=%0d cyc=%0d w=%0d want idx %0d",
                    n, m, gi, pi, gc, gw, ex); end
            total++; if (pc !== exp_rsp_cyc(eo, alu_lat, alu_hang) || sc !== exp_start(eo, alu_lat, alu_hang)
                         || rc !== exp_rstlow(eo, alu_hang)) begin
                bad++; $display("FAIL rnd_timing n=%0d op=%b got rsp=%0d start=%0d rst=%0d want %0d/%0d/%0d",
                    n, eo, pc, sc, rc, exp_rsp_cyc(eo, alu_lat, alu_hang), exp_start(eo, alu_lat, alu_hang),
                    exp_rstlow(eo, alu_hang)); end
            total++; if (pr !== exp_res(eo, a_t[ex], b_t[ex], alu_hang) || pe !== exp_err(eo, alu_hang)) begin
                bad++; $display("FAIL rnd_result n=%0d op=%b got res=%h err=%b want %h/%b", n, eo, pr, pe,
                    exp_res(eo, a_t[ex], b_t[ex], alu_hang), exp_err(eo, alu_hang)); end
        end
        alu_hang = 0;
    endtask

    task automatic test_reset_mid_exec();
        int gc, gi, gw, sc, rc, pc, pi, ex, seen; logic [15:0] pr; logic pe;
        alu_hang = 1;
        @(negedge clk);
        op_t[0] = 3'b001; a_t[0] = 8'd5; b_t[0] = 8'd6; req = 4'b0001;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        total++; if (alu_if_i.start !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL midrst_exec got start=%b busy=%b want 1/1", alu_if_i.start, busy); end
        reset_n = 1'b0;
        @(negedge clk);
        total++; if ({gnt, rsp_valid, rsp_result, rsp_err, busy, alu_if_i.start, alu_if_i.op,
                      alu_if_i.a, alu_if_i.b, alu_if_i.reset_n} !== '0) begin
            bad++; $display("FAIL midrst_outs got=%h want=0", {gnt, rsp_valid, rsp_result, rsp_err, busy,
                alu_if_i.start, alu_if_i.op, alu_if_i.a, alu_if_i.b, alu_if_i.reset_n}); end
        reset_n = 1'b1;
        mptr = 0;
        seen = 0;
        for (int c = 0; c < TO + 8; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) seen++;
        end
        total++; if (seen !== 0) begin
            bad++; $display("FAIL midrst_dropped got rsp_count=%0d want 0", seen); end
        alu_hang = 0; alu_lat = 1;
        for (int r = 1; r < NREQ; r++) begin op_t[r] = 3'b011; a_t[r] = 8'hF0; b_t[r] = 8'h3C; end
        req = 4'b1110;
        observe(1, gc, gi, gw, sc, rc, pc, pi, pr, pe);
        req = '0;
        ex = rr_next(4'b1110, mptr);
        mptr = ex;
        total++; if (gi !== ex || gi !== 1) begin
            bad++; $display("FAIL midrst_ptr got gnt=%0d want %0d", gi, ex); end
        total++; if (pr !== 16'h00CC || pe !== 1'b0 || pi !== 1) begin
            bad++; $display("FAIL midrst_result got res=%h err=%b idx=%0d want 00cc/0/1", pr, pe, pi); end
    endtask

    initial begin
        reset_n = 1'b0;
        req = '0;
        for (int r = 0; r < NREQ; r++) begin op_t[r] = '0; a_t[r] = '0; b_t[r] = '0; end
        test_reset();
        test_single_add();
        test_fairness();
        test_noop();
        test_watchdog();
        test_rst_op();
        test_random();
        test_reset_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
